// File: rtl/first_nios2_system_sysid_checker.sv
// Read sequencer and checker for the sysid slave.
// Reads ID and timestamp words, compares them, keeps sticky status.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1363792568,
    parameter int          READ_LATENCY = 0,
    parameter int          CHECK_PERIOD = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        checked,
    output logic [7:0]  mismatch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WAIT_ID,
        S_RD_TS,
        S_WAIT_TS,
        S_FIN
    } state_t;

    localparam bit         ZERO_LAT = (READ_LATENCY == 0);
    localparam bit         PER_EN   = (CHECK_PERIOD != 0);
    localparam logic [3:0] LAT_M1   = 4'(READ_LATENCY - 1);
    localparam logic [23:0] PER_M1  = 24'(CHECK_PERIOD - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_lat;
    logic [23:0] r_per;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_checked;
    logic [7:0]  r_mcnt;
    logic        w_tick;
    logic        w_lat_end;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_id_match;
    logic        w_ts_match;

    assign w_tick     = PER_EN && (r_per == PER_M1);
    assign w_lat_end  = (r_lat == LAT_M1);
    assign w_id_match = (r_id_value == EXPECTED_ID);
    assign w_ts_match = (r_ts_value == EXPECTED_TS);

    assign id_value       = r_id_value;
    assign ts_value       = r_ts_value;
    assign id_ok          = r_id_ok;
    assign ts_ok          = r_ts_ok;
    assign checked        = r_checked;
    assign mismatch_count = r_mcnt;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state, bus strobes and capture enables
    always_comb begin
        w_next        = r_state;
        sysid_read    = 1'b0;
        sysid_address = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        w_cap_id      = 1'b0;
        w_cap_ts      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start || w_tick) w_next = S_RD_ID;
            end
            S_RD_ID: begin
                sysid_read = 1'b1;
                if (ZERO_LAT) begin
                    w_cap_id = 1'b1;
                    w_next   = S_RD_TS;
                end else begin
                    w_next = S_WAIT_ID;
                end
            end
            S_WAIT_ID: begin
                if (w_lat_end) begin
                    w_cap_id = 1'b1;
                    w_next   = S_RD_TS;
                end
            end
            S_RD_TS: begin
                sysid_read    = 1'b1;
                sysid_address = 1'b1;
                if (ZERO_LAT) begin
                    w_cap_ts = 1'b1;
                    w_next   = S_FIN;
                end else begin
                    w_next = S_WAIT_TS;
                end
            end
            S_WAIT_TS: begin
                sysid_address = 1'b1;
                if (w_lat_end) begin
                    w_cap_ts = 1'b1;
                    w_next   = S_FIN;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Read-latency counter, runs only in the wait states
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_lat <= 4'd0;
        end else if ((r_state == S_WAIT_ID || r_state == S_WAIT_TS)
                     && !w_lat_end) begin
            r_lat <= r_lat + 4'd1;
        end else begin
            r_lat <= 4'd0;
        end
    end

    // Free-running period counter for auto checks
    always_ff @(posedge clock) begin
        if (!reset_n || !PER_EN) r_per <= 24'd0;
        else if (w_tick)         r_per <= 24'd0;
        else                     r_per <= r_per + 24'd1;
    end

    // Word capture and sticky check status
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_checked  <= 1'b0;
            r_mcnt     <= 8'd0;
        end else begin
            if (w_cap_id) r_id_value <= sysid_readdata;
            if (w_cap_ts) r_ts_value <= sysid_readdata;
            if (r_state == S_FIN) begin
                r_id_ok   <= w_id_match;
                r_ts_ok   <= w_ts_match;
                r_checked <= 1'b1;
                if (!(w_id_match && w_ts_match) && r_mcnt != 8'hFF)
                    r_mcnt <= r_mcnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: three instances with different latency
// and period settings, each checked against a phase-count model.
module tb_first_nios2_system_sysid_checker;

    localparam int NI = 3;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1363792568;
    localparam logic [31:0] BAD = 32'h0BAD_F00D;

    function automatic int lat_of(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    function automatic int per_of(input int i);
        return (i == 2) ? 50 : 0;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [NI-1:0] start = '0;
    logic [31:0]   id_resp [NI];
    logic [31:0]   ts_resp [NI];

    logic [NI-1:0] rd_w, ad_w, busy_w, done_w;
    logic [NI-1:0] idok_w, tsok_w, chk_w;
    logic [31:0]   rdata_w [NI];
    logic [31:0]   idv_w [NI];
    logic [31:0]   tsv_w [NI];
    logic [7:0]    mc_w [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = lat_of(g);
        logic [15:0] rd_sh = '0;
        logic [15:0] ad_sh = '0;
        always @(posedge clk) begin
            rd_sh <= {rd_sh[14:0], rd_w[g]};
            ad_sh <= {ad_sh[14:0], ad_w[g]};
        end
        if (L == 0) begin : g_comb
            assign rdata_w[g] = rd_w[g]
                ? (ad_w[g] ? ts_resp[g] : id_resp[g]) : BAD;
        end else begin : g_dly
            assign rdata_w[g] = rd_sh[L-1]
                ? (ad_sh[L-1] ? ts_resp[g] : id_resp[g]) : BAD;
        end
        first_nios2_system_sysid_checker #(
            .EXPECTED_ID (EID),
            .EXPECTED_TS (ETS),
            .READ_LATENCY(L),
            .CHECK_PERIOD(per_of(g))
        ) u_dut (
            .clock         (clk),
            .reset_n       (rst_n),
            .start         (start[g]),
            .sysid_address (ad_w[g]),
            .sysid_read    (rd_w[g]),
            .sysid_readdata(rdata_w[g]),
            .busy          (busy_w[g]),
            .done          (done_w[g]),
            .id_value      (idv_w[g]),
            .ts_value      (tsv_w[g]),
            .id_ok         (idok_w[g]),
            .ts_ok         (tsok_w[g]),
            .checked       (chk_w[g]),
            .mismatch_count(mc_w[g])
        );
    end

    // Model: ph = cycles since launch (0 = idle), last phase is FIN
    int          m_ph [NI];
    int          m_n  [NI];
    int          m_mc [NI];
    logic [31:0] m_id [NI];
    logic [31:0] m_ts [NI];
    logic        m_iok [NI];
    logic        m_tok [NI];
    logic        m_chk [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int ph, n, mc, L, P;
            logic [31:0] idv, tsv;
            logic ok1, ok2, ck;
            L = lat_of(i);
            P = per_of(i);
            ph = m_ph[i]; n = m_n[i]; mc = m_mc[i];
            idv = m_id[i]; tsv = m_ts[i];
            ok1 = m_iok[i]; ok2 = m_tok[i]; ck = m_chk[i];
            if (!rst_n) begin
                ph = 0; n = 0; mc = 0;
                idv = '0; tsv = '0;
                ok1 = 0; ok2 = 0; ck = 0;
            end else begin
                n = n + 1;
                if (ph == 0) begin
                    if (start[i] || (P > 0 && n % P == 0)) ph = 1;
                end else begin
                    if (ph == 1 + L) idv = id_resp[i];
                    if (ph == 2 + 2*L) tsv = ts_resp[i];
                    if (ph == 3 + 2*L) begin
                        ok1 = (idv == EID);
                        ok2 = (tsv == ETS);
                        ck = 1;
                        if (!(ok1 && ok2) && mc < 255) mc = mc + 1;
                        ph = 0;
                    end else begin
                        ph = ph + 1;
                    end
                end
            end
            m_ph[i] <= ph; m_n[i] <= n; m_mc[i] <= mc;
            m_id[i] <= idv; m_ts[i] <= tsv;
            m_iok[i] <= ok1; m_tok[i] <= ok2; m_chk[i] <= ck;
        end
    end

    int tests = 0;
    int errs  = 0;
    int cyc   = 0;
    int dcnt [NI];

    task automatic check(input string nm, input int inst,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h",
                     nm, inst, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            int ph, L;
            logic [3:0] ectl;
            ph = m_ph[i];
            L = lat_of(i);
            ectl = {ph != 0,
                    ph == 1 || ph == 2 + L,
                    ph >= 2 + L && ph < 3 + 2*L,
                    ph == 3 + 2*L};
            check("ctl", i,
                  32'({busy_w[i], rd_w[i], ad_w[i], done_w[i]}),
                  32'(ectl));
            check("id_value", i, idv_w[i], m_id[i]);
            check("ts_value", i, tsv_w[i], m_ts[i]);
            check("flags", i,
                  32'({idok_w[i], tsok_w[i], chk_w[i]}),
                  32'({m_iok[i], m_tok[i], m_chk[i]}));
            check("mcount", i, 32'(mc_w[i]), 32'(m_mc[i]));
            if (done_w[i]) dcnt[i]++;
        end
    endtask

    initial begin
        int k, rc, d;
        for (int i = 0; i < NI; i++) begin
            id_resp[i] = EID;
            ts_resp[i] = ETS;
            dcnt[i] = 0;
        end
        ts_resp[2] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_busy", 0, 32'(busy_w), 32'd0);
        check("rst_chk", 0, 32'(chk_w), 32'd0);

        // basic check, zero latency
        repeat (7) step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("t1_rd_a0", 0, 32'({rd_w[0], ad_w[0]}), 32'b10);
        step();
        check("t1_rd_a1", 0, 32'({rd_w[0], ad_w[0]}), 32'b11);
        step();
        check("t1_done", 0, 32'(done_w[0]), 32'd1);
        step();
        check("t1_ok", 0, 32'({idok_w[0], tsok_w[0]}), 32'b11);
        check("t1_cnt", 0, 32'(mc_w[0]), 32'd0);

        // two checks with bad timestamp
        ts_resp[0] = 32'hDEADBEEF;
        repeat (2) begin
            start[0] = 1'b1;
            step();
            start[0] = 1'b0;
            repeat (5) step();
        end
        check("t2_cnt", 0, 32'(mc_w[0]), 32'd2);
        check("t2_ok", 0, 32'({idok_w[0], tsok_w[0]}), 32'b10);
        check("t2_tsv", 0, tsv_w[0], 32'hDEADBEEF);
        ts_resp[0] = ETS;

        // latency 3 instance
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        k = 1;
        rc = int'(rd_w[1]);
        while (!done_w[1] && k < 20) begin
            step();
            k++;
            rc += int'(rd_w[1]);
        end
        check("t3_lat", 1, 32'(k), 32'd9);
        check("t3_reads", 1, 32'(rc), 32'd2);
        step();
        check("t3_ok", 1, 32'({idok_w[1], tsok_w[1]}), 32'b11);

        // start held high for 20 cycles
        repeat (3) step();
        d = dcnt[0];
        start[0] = 1'b1;
        repeat (20) step();
        start[0] = 1'b0;
        repeat (6) step();
        check("t4_dones", 0, 32'(dcnt[0] - d), 32'd5);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                start[i] = ($urandom_range(7) == 0);
                if ($urandom_range(15) == 0)
                    id_resp[i] = ($urandom_range(3) == 0)
                                 ? 32'($urandom) : EID;
                if ($urandom_range(15) == 0)
                    ts_resp[i] = ($urandom_range(3) == 0)
                                 ? 32'($urandom) : ETS;
            end
            rst_n = ($urandom_range(499) != 0);
            step();
        end
        rst_n = 1'b1;
        start = '0;
        for (int i = 0; i < NI; i++) begin
            id_resp[i] = EID;
            ts_resp[i] = ETS;
        end
        ts_resp[2] = 32'hDEADBEEF;

        // periodic checks until saturation
        repeat (14100) step();
        d = dcnt[2];
        repeat (1000) step();
        check("t5_period", 2, 32'(dcnt[2] - d), 32'd20);
        check("t5_sat", 2, 32'(mc_w[2]), 32'd255);

        // reset during WAIT_TS
        step();
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (5) step();
        check("t6_in_wait", 1, 32'({busy_w[1], ad_w[1], rd_w[1]}),
              32'b110);
        rst_n = 1'b0;
        step();
        check("t6_busy", 1, 32'(busy_w), 32'd0);
        check("t6_done", 1, 32'(done_w), 32'd0);
        check("t6_chk", 1, 32'(chk_w), 32'd0);
        check("t6_mc", 2, 32'(mc_w[2]), 32'd0);
        check("t6_idv", 1, idv_w[1], 32'd0);
        rst_n = 1'b1;
        step();
        d = dcnt[1];
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (10) step();
        check("t6_redo", 1, 32'(dcnt[1] - d), 32'd1);
        check("t6_ok", 1, 32'({idok_w[1], tsok_w[1], chk_w[1]}),
              32'b111);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
